// File: rtl/mem_unit_if.sv
// mem_unit_if: request/response bus between a requester and mem_unit.
// Request side:  req_valid, write_enable, funct3, addr, data_in (master -> slave); req_ready (slave -> master)
// Response side: resp_valid, data_out, fault (slave -> master)
interface mem_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        write_enable;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] data_in;
   logic        resp_valid;
   logic [31:0] data_out;
   logic        fault;
   modport master (
      output req_valid, write_enable, funct3, addr, data_in,
      input  req_ready, resp_valid, data_out, fault
   );
   modport slave (
      input  req_valid, write_enable, funct3, addr, data_in,
      output req_ready, resp_valid, data_out, fault
   );
endinterface

// File: rtl/mem_unit.sv
// mem_unit: RV32I-style byte-addressable data RAM with a memory-mapped display register.
// Ports: clk, rst (async, active-high), clk_enable (global advance enable),
//        bus (mem_unit_if.slave request/response handshake),
//        display_out (16-bit active-low display register).
module mem_unit #(
   parameter int          ADDR_WIDTH   = 9,
   parameter logic [31:0] DISPLAY_ADDR = 32'h0000_07FC,
   parameter              INIT_FILE    = "memory_init/mem-init"
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_enable,
   mem_unit_if.slave   bus,
   output logic [15:0] display_out
);
   typedef enum logic {IDLE, RESP} state_t;
   state_t                state;
   logic [31:0]           mem [2**ADDR_WIDTH];
   logic [ADDR_WIDTH-1:0] idx;
   logic                  accept;
   logic                  disp_hit;
   logic                  bad;
   logic                  wr_ram;
   logic [3:0]            lanes;
   logic [31:0]           wdata;
   logic [31:0]           rd_q;
   logic [1:0]            lo_q;
   logic [2:0]            f3_q;
   logic                  we_q;
   logic                  hit_q;
   logic                  resp_q;
   logic                  fault_q;
   logic [31:0]           src;
   logic [7:0]            bt;
   logic [15:0]           hw;
   logic [31:0]           ext;

   assign bus.req_ready = state == IDLE;
   assign accept        = bus.req_ready && bus.req_valid && clk_enable;
   assign idx           = bus.addr[ADDR_WIDTH+1:2];
   assign disp_hit      = bus.addr[31:2] == DISPLAY_ADDR[31:2];
   assign bus.resp_valid = resp_q;
   assign bus.fault      = fault_q;

   // funct3[1:0] selects the size (00 byte, 01 half, 10 word); bit 2 only chooses zero-extension on loads
   always_comb begin
      bad = bus.funct3 == 3'b011 || bus.funct3[2:1] == 2'b11
         || (bus.funct3[1:0] == 2'b01 && bus.addr[0])
         || (bus.funct3 == 3'b010 && bus.addr[1:0] != 2'b00)
         || (bus.write_enable && disp_hit && bus.funct3[1:0] == 2'b00);
      lanes = bus.funct3[1:0] == 2'b00 ? 4'b0001 << bus.addr[1:0]
            : bus.funct3[1:0] == 2'b01 ? (bus.addr[1] ? 4'b1100 : 4'b0011)
            : 4'b1111;
      wdata = bus.funct3[1:0] == 2'b00 ? {4{bus.data_in[7:0]}}
            : bus.funct3[1:0] == 2'b01 ? {2{bus.data_in[15:0]}}
            : bus.data_in;
      // rst is sampled here so a store presented on the edge that releases reset is dropped
      wr_ram = accept && bus.write_enable && !bad && !disp_hit && !rst;
   end

   // RAM has no reset so its contents survive rst
   always_ff @(posedge clk) begin
      if (wr_ram)
         for (int i = 0; i < 4; i++)
            if (lanes[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      if (accept) rd_q <= mem[idx];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         resp_q      <= 1'b0;
         fault_q     <= 1'b0;
         display_out <= 16'hFFFF;
         lo_q        <= 2'b00;
         f3_q        <= 3'b000;
         we_q        <= 1'b0;
         hit_q       <= 1'b0;
      end else if (clk_enable) begin
         if (state == IDLE) begin
            if (bus.req_valid) begin
               state   <= RESP;
               resp_q  <= 1'b1;
               fault_q <= bad;
               lo_q    <= bus.addr[1:0];
               f3_q    <= bus.funct3;
               we_q    <= bus.write_enable;
               hit_q   <= disp_hit;
               if (bus.write_enable && disp_hit && !bad) display_out <= ~bus.data_in[15:0];
            end
         end else begin
            state   <= IDLE;
            resp_q  <= 1'b0;
            fault_q <= 1'b0;
         end
      end
   end

   // display_out cannot change while in RESP, so reading it live gives the value seen at accept
   always_comb begin
      src = hit_q ? {16'h0000, ~display_out} : rd_q;
      bt  = 8'(src >> {lo_q, 3'b000});
      hw  = lo_q[1] ? src[31:16] : src[15:0];
      ext = f3_q == 3'b000 ? {{24{bt[7]}}, bt}
          : f3_q == 3'b001 ? {{16{hw[15]}}, hw}
          : f3_q == 3'b100 ? {24'h000000, bt}
          : f3_q == 3'b101 ? {16'h0000, hw}
          : src;
      bus.data_out = (resp_q && !fault_q && !we_q) ? ext : 32'h0000_0000;
   end
endmodule
